// File: rtl/corescore_reset_seq.sv
`default_nettype none
// corescore_reset_seq: staggered per-group reset release after a synchronized reset.
// Rev 1.0
module corescore_reset_seq #(
  parameter int unsigned GROUPS      = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_soft_rst,
  output logic [GROUPS-1:0] o_rst,
  output logic              o_done
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = $clog2(GROUPS + 1);

  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_STAG = CW'(STAGGER - 1);
  localparam logic [IW-1:0] C_LAST = IW'(GROUPS);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  logic [1:0]        sync_q;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GROUPS-1:0] rst_q, rst_d;
  logic              done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    if ((state_q != ST_RESET) && i_soft_rst) begin
      state_d = ST_HOLD;
      cnt_d   = C_HOLD;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          // Leave on the edge that clears the last synchronizer stage.
          if (sync_q != 2'b11) begin
            state_d = ST_HOLD;
            cnt_d   = C_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            rst_d[0] = 1'b0;
            idx_d    = IW'(1);
            cnt_d    = C_STAG;
            state_d  = ST_RELEASE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (idx_q == C_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (cnt_q == '0) begin
            for (int k = 0; k < int'(GROUPS); k++) begin
              if (IW'(k) == idx_q) rst_d[k] = 1'b0;
            end
            idx_d = idx_q + 1'b1;
            cnt_d = C_STAG;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  assign o_rst  = rst_q;
  assign o_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_corescore_reset_seq.sv
`default_nettype none
// tb_corescore_reset_seq: scoreboard bench for the staggered reset sequencer.
// Rev 1.0
module tb_corescore_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, soft_a = 1'b0;
  logic rst_b = 1'b0, soft_b = 1'b0;
  logic rst_c = 1'b0, soft_c = 1'b0;

  logic [3:0]  o_rst_a;
  logic        o_done_a;
  logic [0:0]  o_rst_b;
  logic        o_done_b;
  logic [31:0] o_rst_c;
  logic        o_done_c;

  corescore_reset_seq #(.GROUPS(4), .HOLD_CYCLES(8), .STAGGER(3)) u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_soft_rst(soft_a), .o_rst(o_rst_a), .o_done(o_done_a));
  corescore_reset_seq #(.GROUPS(1), .HOLD_CYCLES(0), .STAGGER(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_soft_rst(soft_b), .o_rst(o_rst_b), .o_done(o_done_b));
  corescore_reset_seq #(.GROUPS(32), .HOLD_CYCLES(2), .STAGGER(1)) u_dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_soft_rst(soft_c), .o_rst(o_rst_c), .o_done(o_done_c));

  wire logic [32:0] obs_a = {o_done_a, 28'd0, o_rst_a};
  wire logic [32:0] obs_b = {o_done_b, 31'd0, o_rst_b};
  wire logic [32:0] obs_c = {o_done_c, o_rst_c};

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          n;
    logic [32:0] v;
  } exp_t;
  exp_t sb[$];

  // Edge n (relative to the reference edge) clears group k once n >= off+h+k*s.
  function automatic logic [32:0] exp_out(int g, int h, int s, int off, int n);
    logic [31:0] r;
    logic        d;
    r = '0;
    for (int k = 0; k < g; k++) r[k] = (n >= off + h + k * s) ? 1'b0 : 1'b1;
    d = (n >= off + h + (g - 1) * s + 1);
    return {d, r};
  endfunction

  task automatic push_seq(input int g, input int h, input int s, input int off,
                          input int n_from, input int n_to);
    exp_t e;
    for (int n = n_from; n <= n_to; n++) begin
      e.n = n;
      e.v = exp_out(g, h, s, off, n);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    total++;
    if (obs_a !== {1'b0, 28'd0, 4'hF}) begin
      bad++; $display("FAIL reset_a: got %h want %h", obs_a, {1'b0, 28'd0, 4'hF});
    end
    total++;
    if (obs_b !== {1'b0, 31'd0, 1'b1}) begin
      bad++; $display("FAIL reset_b: got %h want %h", obs_b, {1'b0, 31'd0, 1'b1});
    end
    total++;
    if (obs_c !== {1'b0, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL reset_c: got %h want %h", obs_c, {1'b0, 32'hFFFF_FFFF});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_a !== {1'b0, 28'd0, 4'hF}) begin
      bad++; $display("FAIL reset_held: got %h want %h", obs_a, {1'b0, 28'd0, 4'hF});
    end
  endtask

  task automatic test_powerup();
    exp_t e;
    @(negedge clk);
    rst_a = 1'b0;
    push_seq(4, 8, 3, 2, 0, 24);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL powerup E%0d: got %h want %h", e.n, obs_a, e.v);
      end
    end
  endtask

  task automatic test_async_mid();
    exp_t e;
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    push_seq(4, 8, 3, 2, 0, 14);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL async_pre E%0d: got %h want %h", e.n, obs_a, e.v);
      end
    end
    #1 rst_a = 1'b1;
    #1;
    total++;
    if (obs_a !== {1'b0, 28'd0, 4'hF}) begin
      bad++; $display("FAIL async_immediate: got %h want %h", obs_a, {1'b0, 28'd0, 4'hF});
    end
    #1 rst_a = 1'b0;
    push_seq(4, 8, 3, 2, 0, 22);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL async_rerun E%0d: got %h want %h", e.n, obs_a, e.v);
      end
    end
  endtask

  task automatic test_soft_done();
    exp_t e;
    @(negedge clk);
    soft_a = 1'b1;
    push_seq(4, 8, 3, 1, 0, 22);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL soft_done S+%0d: got %h want %h", e.n, obs_a, e.v);
      end
      if (e.n == 0) soft_a = 1'b0;
    end
  endtask

  task automatic test_soft_hold();
    exp_t e;
    @(negedge clk);
    soft_a = 1'b1;
    push_seq(4, 8, 3, 1, 0, 12);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL soft_pre S+%0d: got %h want %h", e.n, obs_a, e.v);
      end
      if (e.n == 0) soft_a = 1'b0;
    end
    // Mid-release: hold the request for three edges; the sequence keys off the last one.
    soft_a = 1'b1;
    push_seq(4, 8, 3, 1, -2, 22);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL soft_hold S+%0d: got %h want %h", e.n, obs_a, e.v);
      end
      if (e.n == 0) soft_a = 1'b0;
    end
  endtask

  task automatic test_simul();
    exp_t e;
    @(negedge clk);
    rst_a  = 1'b1;
    soft_a = 1'b1;
    #1;
    total++;
    if (obs_a !== {1'b0, 28'd0, 4'hF}) begin
      bad++; $display("FAIL simul_immediate: got %h want %h", obs_a, {1'b0, 28'd0, 4'hF});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    push_seq(4, 8, 3, 2, 0, 21);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_a !== e.v) begin
        bad++; $display("FAIL simul E%0d: got %h want %h", e.n, obs_a, e.v);
      end
      if (e.n == 0) soft_a = 1'b0;
    end
  endtask

  task automatic test_boundary_g1();
    exp_t e;
    @(negedge clk);
    rst_b = 1'b0;
    push_seq(1, 0, 1, 2, 0, 6);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_b !== e.v) begin
        bad++; $display("FAIL g1 E%0d: got %h want %h", e.n, obs_b, e.v);
      end
    end
  endtask

  task automatic test_boundary_g32();
    exp_t e;
    @(negedge clk);
    rst_c = 1'b0;
    push_seq(32, 2, 1, 2, 0, 40);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs_c !== e.v) begin
        bad++; $display("FAIL g32 E%0d: got %h want %h", e.n, obs_c, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_async_mid();
    test_soft_done();
    test_soft_hold();
    test_simul();
    test_boundary_g1();
    test_boundary_g32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
